// File: rtl/pa_ifu_bht_pkg.sv
// pa_ifu_bht_pkg: shared widths, constants, FSM state type and the
// saturating 2-bit counter helper for the IFU branch history table.
package pa_ifu_bht_pkg;

  localparam int unsigned IDX_W    = 9;
  localparam int unsigned ENTRY_W  = 16;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned STARVE_W = 3;

  localparam logic [CNT_W-1:0]    INIT_CNT    = 2'b01;
  localparam logic [ENTRY_W-1:0]  INIT_WORD   = {(ENTRY_W/CNT_W){INIT_CNT}};
  localparam logic [IDX_W-1:0]    IDX_LAST    = {IDX_W{1'b1}};
  localparam logic [STARVE_W-1:0] STARVE_MAX  = 3'd4;
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_MAX - 3'd1;
  localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_MIN     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPD_RD = 2'd2,
    ST_UPD_WR = 2'd3
  } bht_state_e;

  // Move a 2-bit predictor one step toward the resolved direction, saturating.
  function automatic logic [CNT_W-1:0] sat_cnt_upd(input logic [CNT_W-1:0] cnt,
                                                   input logic             taken);
    logic [CNT_W-1:0] res;
    if (taken) begin
      if (cnt == CNT_MAX) res = cnt;
      else                res = cnt + CNT_ONE;
    end else begin
      if (cnt == CNT_MIN) res = cnt;
      else                res = cnt - CNT_ONE;
    end
    return res;
  endfunction

endpackage

// File: rtl/pa_ifu_bht_ctrl_if.sv
// pa_ifu_bht_ctrl_if: lookup, update and SRAM-side signals of the BHT
// controller. master = surrounding IFU/array, slave = the controller.
interface pa_ifu_bht_ctrl_if;
  import pa_ifu_bht_pkg::*;

  logic               pred_vld;
  logic [IDX_W-1:0]   pred_idx;
  logic [SEL_W-1:0]   pred_sel;
  logic               pred_rdy;
  logic               pred_rslt_vld;
  logic               pred_taken;
  logic [CNT_W-1:0]   pred_cnt;
  logic               upd_vld;
  logic [IDX_W-1:0]   upd_idx;
  logic [SEL_W-1:0]   upd_sel;
  logic               upd_taken;
  logic               upd_rdy;
  logic               bht_inv;
  logic               bht_init_busy;
  logic               bht_cen;
  logic [IDX_W-1:0]   bht_idx;
  logic [ENTRY_W-1:0] bht_din;
  logic [ENTRY_W-1:0] bht_wen;
  logic [ENTRY_W-1:0] bht_dout;

  modport master (
    output pred_vld, pred_idx, pred_sel, upd_vld, upd_idx, upd_sel, upd_taken,
           bht_inv, bht_dout,
    input  pred_rdy, pred_rslt_vld, pred_taken, pred_cnt, upd_rdy,
           bht_init_busy, bht_cen, bht_idx, bht_din, bht_wen
  );

  modport slave (
    input  pred_vld, pred_idx, pred_sel, upd_vld, upd_idx, upd_sel, upd_taken,
           bht_inv, bht_dout,
    output pred_rdy, pred_rslt_vld, pred_taken, pred_cnt, upd_rdy,
           bht_init_busy, bht_cen, bht_idx, bht_din, bht_wen
  );

endinterface

// File: rtl/pa_ifu_bht_upd_buf.sv
// pa_ifu_bht_upd_buf: single-entry buffer for retired-branch updates plus
// the counter of cycles the buffered update has lost the port to lookups.
module pa_ifu_bht_upd_buf
  import pa_ifu_bht_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic                i_taken,
  input  logic                i_free,
  input  logic                i_blocked,
  input  logic                i_starve_clr,
  output logic                o_vld,
  output logic [IDX_W-1:0]    o_idx,
  output logic [SEL_W-1:0]    o_sel,
  output logic                o_taken,
  output logic [STARVE_W-1:0] o_starve
);

  logic                r_vld;
  logic [IDX_W-1:0]    r_idx;
  logic [SEL_W-1:0]    r_sel;
  logic                r_taken;
  logic [STARVE_W-1:0] r_starve;

  // Buffer occupancy and payload; a load in the freeing cycle refills it
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_vld   <= 1'b0;
      r_idx   <= {IDX_W{1'b0}};
      r_sel   <= {SEL_W{1'b0}};
      r_taken <= 1'b0;
    end else if (i_load) begin
      r_vld   <= 1'b1;
      r_idx   <= i_idx;
      r_sel   <= i_sel;
      r_taken <= i_taken;
    end else if (i_free) begin
      r_vld   <= 1'b0;
      r_idx   <= r_idx;
      r_sel   <= r_sel;
      r_taken <= r_taken;
    end else begin
      r_vld   <= r_vld;
      r_idx   <= r_idx;
      r_sel   <= r_sel;
      r_taken <= r_taken;
    end
  end

  // Starvation count: saturating, cleared once the update owns the port
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || i_starve_clr) begin
      r_starve <= {STARVE_W{1'b0}};
    end else if (i_blocked && (r_starve != STARVE_MAX)) begin
      r_starve <= r_starve + 3'd1;
    end else begin
      r_starve <= r_starve;
    end
  end

  assign o_vld    = r_vld;
  assign o_idx    = r_idx;
  assign o_sel    = r_sel;
  assign o_taken  = r_taken;
  assign o_starve = r_starve;

endmodule

// File: rtl/pa_ifu_bht_ctrl.sv
// pa_ifu_bht_ctrl: requester side of the IFU BHT SRAM. Serves 1-cycle
// prediction lookups, read-modify-write counter updates and the
// post-reset initialisation walk over all entries.
// Optional feature macro: PA_IFU_BHT_INV_EN (bht_inv re-initialises table).
module pa_ifu_bht_ctrl
  import pa_ifu_bht_pkg::*;
(
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  pa_ifu_bht_ctrl_if.slave bht_if
);

  bht_state_e          r_state;
  bht_state_e          w_state_nxt;
  logic [IDX_W-1:0]    r_init_ctr;
  logic [IDX_W-1:0]    w_init_ctr_nxt;
  logic                r_rslt_vld;
  logic [SEL_W-1:0]    r_rslt_sel;

  logic                w_inv;
  logic                w_buf_vld;
  logic [IDX_W-1:0]    w_buf_idx;
  logic [SEL_W-1:0]    w_buf_sel;
  logic                w_buf_taken;
  logic [STARVE_W-1:0] w_starve;
  logic                w_starved;
  logic                w_pred_rdy;
  logic                w_upd_rdy;
  logic                w_pred_acc;
  logic                w_upd_acc;
  logic                w_blocked;
  logic [CNT_W-1:0]    w_old_cnt;
  logic [CNT_W-1:0]    w_new_cnt;
  logic [CNT_W-1:0]    w_pred_cnt;
  logic                w_cen;
  logic [IDX_W-1:0]    w_idx;
  logic [ENTRY_W-1:0]  w_din;
  logic [ENTRY_W-1:0]  w_wen;

`ifdef PA_IFU_BHT_INV_EN
  assign w_inv = bht_if.bht_inv;
`else
  assign w_inv = 1'b0;
`endif

  // Port arbitration: lookups own the port unless the update has starved
  assign w_starved  = w_buf_vld && (w_starve == STARVE_MAX);
  assign w_pred_rdy = (r_state == ST_IDLE) && !w_starved && !w_inv && !cpurst;
  assign w_upd_rdy  = (((r_state == ST_IDLE) && !w_buf_vld) || (r_state == ST_UPD_WR))
                      && !w_inv && !cpurst;
  assign w_pred_acc = bht_if.pred_vld && w_pred_rdy;
  assign w_upd_acc  = bht_if.upd_vld && w_upd_rdy;
  assign w_blocked  = (r_state == ST_IDLE) && w_buf_vld && w_pred_acc;

  pa_ifu_bht_upd_buf u_upd_buf (
    .i_clk        (forever_cpuclk),
    .i_rst        (cpurst),
    .i_clr        (w_inv),
    .i_load       (w_upd_acc),
    .i_idx        (bht_if.upd_idx),
    .i_sel        (bht_if.upd_sel),
    .i_taken      (bht_if.upd_taken),
    .i_free       (r_state == ST_UPD_WR),
    .i_blocked    (w_blocked),
    .i_starve_clr (r_state == ST_UPD_RD),
    .o_vld        (w_buf_vld),
    .o_idx        (w_buf_idx),
    .o_sel        (w_buf_sel),
    .o_taken      (w_buf_taken),
    .o_starve     (w_starve)
  );

  // Read data from the UPD_RD access is the old word; bump the selected counter
  assign w_old_cnt = bht_if.bht_dout[{w_buf_sel, 1'b0} +: CNT_W];
  assign w_new_cnt = sat_cnt_upd(w_old_cnt, w_buf_taken);

  // Next state: init walk, lookup/update arbitration, RMW sequencing
  always_comb begin
    w_state_nxt    = r_state;
    w_init_ctr_nxt = r_init_ctr;
    case (r_state)
      ST_INIT: begin
        w_init_ctr_nxt = r_init_ctr + 9'd1;
        if (r_init_ctr == IDX_LAST) w_state_nxt = ST_IDLE;
        else                        w_state_nxt = ST_INIT;
      end
      ST_IDLE: begin
        // The 4th lost cycle still serves its lookup, then the update takes over
        if (w_buf_vld && (!w_pred_acc || (w_starve == STARVE_LAST))) w_state_nxt = ST_UPD_RD;
        else                                                         w_state_nxt = ST_IDLE;
      end
      ST_UPD_RD: w_state_nxt = ST_UPD_WR;
      ST_UPD_WR: w_state_nxt = ST_IDLE;
      default: begin
        w_state_nxt    = ST_INIT;
        w_init_ctr_nxt = {IDX_W{1'b0}};
      end
    endcase
    if (w_inv) begin
      w_state_nxt    = ST_INIT;
      w_init_ctr_nxt = {IDX_W{1'b0}};
    end else begin
      w_state_nxt    = w_state_nxt;
      w_init_ctr_nxt = w_init_ctr_nxt;
    end
  end

  // State, init walk pointer and lookup result tracking
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_state    <= ST_INIT;
      r_init_ctr <= {IDX_W{1'b0}};
      r_rslt_vld <= 1'b0;
      r_rslt_sel <= {SEL_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_init_ctr <= w_init_ctr_nxt;
      r_rslt_vld <= w_pred_acc;
      if (w_pred_acc) r_rslt_sel <= bht_if.pred_sel;
      else            r_rslt_sel <= r_rslt_sel;
    end
  end

  // Array access mux: one access per cycle, quiet while reset is held
  always_comb begin
    w_cen = 1'b0;
    w_idx = {IDX_W{1'b0}};
    w_din = {ENTRY_W{1'b0}};
    w_wen = {ENTRY_W{1'b0}};
    case (r_state)
      ST_INIT: begin
        w_cen = 1'b1;
        w_idx = r_init_ctr;
        w_din = INIT_WORD;
        w_wen = {ENTRY_W{1'b1}};
      end
      ST_IDLE: begin
        if (w_pred_acc) begin
          w_cen = 1'b1;
          w_idx = bht_if.pred_idx;
        end else begin
          w_cen = 1'b0;
          w_idx = {IDX_W{1'b0}};
        end
      end
      ST_UPD_RD: begin
        w_cen = 1'b1;
        w_idx = w_buf_idx;
      end
      ST_UPD_WR: begin
        w_cen = 1'b1;
        w_idx = w_buf_idx;
        w_din = {(ENTRY_W/CNT_W){w_new_cnt}};
        w_wen = {{(ENTRY_W-CNT_W){1'b0}}, {CNT_W{1'b1}}} << {w_buf_sel, 1'b0};
      end
      default: begin
        w_cen = 1'b0;
      end
    endcase
    if (cpurst) begin
      w_cen = 1'b0;
      w_wen = {ENTRY_W{1'b0}};
    end else begin
      w_cen = w_cen;
      w_wen = w_wen;
    end
  end

  assign w_pred_cnt = r_rslt_vld ? bht_if.bht_dout[{r_rslt_sel, 1'b0} +: CNT_W] : CNT_MIN;

  assign bht_if.pred_rdy      = w_pred_rdy;
  assign bht_if.pred_rslt_vld = r_rslt_vld;
  assign bht_if.pred_cnt      = w_pred_cnt;
  assign bht_if.pred_taken    = w_pred_cnt[CNT_W-1];
  assign bht_if.upd_rdy       = w_upd_rdy;
  assign bht_if.bht_init_busy = (r_state == ST_INIT) || cpurst;
  assign bht_if.bht_cen       = w_cen;
  assign bht_if.bht_idx       = w_idx;
  assign bht_if.bht_din       = w_din;
  assign bht_if.bht_wen       = w_wen;

endmodule
